quic_dec_pix_out: RTL and testbench

Downstream pixel sink for `quic_dec`. Captures each decoded pixel on `pix_end` and computes its byte address in a linear RGBX frame buffer. Buffers pixels in a small FIFO and presents them on a valid/ready write port. Throttles the decoder through `rd` and reports frame completion once the last decoded pixel has left the port.

---
 rtl/quic_dec_pix_out.sv | 180 ++++++++++++++++++
 tb/tb_quic_dec_pix_out.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/quic_dec_pix_out.sv
// Pixel sink for quic_dec: captures decoded pixels, computes RGBX frame-buffer
// addresses and streams them out through a show-ahead FIFO on a valid/ready port.
module quic_dec_pix_out #(
    parameter int DEPTH = 8,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          pix_end,
    input  logic [7:0]    pix_r,
    input  logic [7:0]    pix_g,
    input  logic [7:0]    pix_b,
    input  logic [15:0]   row_o,
    input  logic [15:0]   column_o,
    input  logic [15:0]   width,
    input  logic          quic_dec_header_end,
    input  logic          decode_end,
    input  logic [AW-1:0] base_addr,
    output logic          rd,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_data,
    output logic          frame_done,
    output logic          overflow,
    output logic [31:0]   pix_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 2;

    logic          hdr_d_r;
    logic          dec_d_r;
    logic [AW-1:0] base_r;
    logic          s1_v_r;
    logic [23:0]   s1_rgb_r;
    logic [15:0]   s1_row_r;
    logic [15:0]   s1_col_r;
    logic          s2_v_r;
    logic [AW-1:0] s2_addr_r;
    logic [31:0]   s2_data_r;
    logic [AW+31:0] mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW:0]   fifo_cnt_r;
    logic          end_seen_r;
    logic          overflow_r;
    logic [31:0]   pix_count_r;

    logic          hdr_rise_s;
    logic          dec_rise_s;
    logic [OW-1:0] occ_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;
    logic          done_s;
    logic [31:0]   off_s;
    logic [AW-1:0] addr_s;
    logic [AW+31:0] head_s;

    // Edge detection, occupancy, address arithmetic and completion condition
    always_comb begin
        hdr_rise_s = quic_dec_header_end & ~hdr_d_r;
        dec_rise_s = decode_end & ~dec_d_r;
        occ_s      = OW'(fifo_cnt_r) + OW'(s1_v_r) + OW'(s2_v_r);
        pop_s      = (fifo_cnt_r != {(PW+1){1'b0}}) && m_ready;
        push_s     = s2_v_r;
        drop_s     = pix_end && (occ_s == OW'(DEPTH)) && !pop_s;
        // Upper operand halves are zero, so this equals the 16x16->32 product
        off_s      = (32'(s1_row_r) * 32'(width)) + 32'(s1_col_r);
        addr_s     = base_r + AW'({off_s, 2'b00});
        done_s     = end_seen_r && (occ_s == {OW{1'b0}}) && !pix_end;
        head_s     = mem_r[rd_ptr_r];
    end

    assign rd         = (occ_s <= OW'(DEPTH - 3));
    assign m_valid    = (fifo_cnt_r != {(PW+1){1'b0}});
    assign m_addr     = head_s[AW+31:32];
    assign m_data     = head_s[31:0];
    assign frame_done = done_s;
    assign overflow   = overflow_r;
    assign pix_count  = pix_count_r;

    // Delayed copies for edge detection and frame base latch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hdr_d_r <= 1'b0;
            dec_d_r <= 1'b0;
            base_r  <= {AW{1'b0}};
        end else begin
            hdr_d_r <= quic_dec_header_end;
            dec_d_r <= decode_end;
            if (hdr_rise_s) begin
                base_r <= base_addr;
            end else begin
                base_r <= base_r;
            end
        end
    end

    // Capture stage S1 and address stage S2
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_v_r    <= 1'b0;
            s1_rgb_r  <= 24'h000000;
            s1_row_r  <= 16'h0000;
            s1_col_r  <= 16'h0000;
            s2_v_r    <= 1'b0;
            s2_addr_r <= {AW{1'b0}};
            s2_data_r <= 32'h00000000;
        end else begin
            s1_v_r <= pix_end && !drop_s;
            if (pix_end) begin
                s1_rgb_r <= {pix_r, pix_g, pix_b};
                s1_row_r <= row_o;
                s1_col_r <= column_o;
            end else begin
                s1_rgb_r <= s1_rgb_r;
                s1_row_r <= s1_row_r;
                s1_col_r <= s1_col_r;
            end
            s2_v_r    <= s1_v_r;
            s2_addr_r <= addr_s;
            s2_data_r <= {8'h00, s1_rgb_r};
        end
    end

    // Show-ahead FIFO; occupancy accounting guarantees no push while full
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {(AW+32){1'b0}};
            end
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            fifo_cnt_r <= {(PW+1){1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= {s2_addr_r, s2_data_r};
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + (PW+1)'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - (PW+1)'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // Frame status: pixel count, sticky overflow, end-of-frame latch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_count_r <= 32'd0;
            overflow_r  <= 1'b0;
            end_seen_r  <= 1'b0;
        end else if (hdr_rise_s) begin
            pix_count_r <= 32'd0;
            overflow_r  <= 1'b0;
            end_seen_r  <= 1'b0;
        end else begin
            pix_count_r <= pop_s ? pix_count_r + 32'd1 : pix_count_r;
            overflow_r  <= overflow_r | drop_s;
            if (dec_rise_s) begin
                end_seen_r <= 1'b1;
            end else if (done_s) begin
                end_seen_r <= 1'b0;
            end else begin
                end_seen_r <= end_seen_r;
            end
        end
    end

endmodule

// File: tb/tb_quic_dec_pix_out.sv
// Directed self-checking bench for quic_dec_pix_out (DEPTH=8, AW=32).
module tb_quic_dec_pix_out;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pix_end;
    logic [7:0]  pix_r, pix_g, pix_b;
    logic [15:0] row_o, column_o, width;
    logic        quic_dec_header_end, decode_end;
    logic [31:0] base_addr;
    logic        rd, m_valid, m_ready;
    logic [31:0] m_addr, m_data;
    logic        frame_done, overflow;
    logic [31:0] pix_count;

    int n_checks = 0;
    int n_pass   = 0;

    quic_dec_pix_out #(.DEPTH(8), .AW(32)) dut (
        .clk(clk), .reset_n(reset_n), .pix_end(pix_end),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .row_o(row_o), .column_o(column_o), .width(width),
        .quic_dec_header_end(quic_dec_header_end), .decode_end(decode_end),
        .base_addr(base_addr), .rd(rd), .m_valid(m_valid), .m_ready(m_ready),
        .m_addr(m_addr), .m_data(m_data), .frame_done(frame_done),
        .overflow(overflow), .pix_count(pix_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input logic [15:0] r, input logic [15:0] c, input logic [23:0] rgb);
        pix_end  = 1'b1;
        row_o    = r;
        column_o = c;
        {pix_r, pix_g, pix_b} = rgb;
    endtask

    task automatic start_frame(input logic [31:0] b, input logic [15:0] w);
        quic_dec_header_end = 1'b0;
        step();
        base_addr = b;
        width     = w;
        quic_dec_header_end = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; pix_end = 1'b0; row_o = 16'd0; column_o = 16'd0;
        pix_r = 8'd0; pix_g = 8'd0; pix_b = 8'd0; width = 16'd0;
        quic_dec_header_end = 1'b0; decode_end = 1'b0; base_addr = 32'd0; m_ready = 1'b0;
        step(); step();
        n_checks++; if (rd !== 1'b1) $display("FAIL reset_rd: got %b want 1", rd); else n_pass++;
        n_checks++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b want 0", m_valid); else n_pass++;
        n_checks++; if (m_addr !== 32'd0) $display("FAIL reset_m_addr: got %h want 0", m_addr); else n_pass++;
        n_checks++; if (m_data !== 32'd0) $display("FAIL reset_m_data: got %h want 0", m_data); else n_pass++;
        n_checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", frame_done); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else n_pass++;
        n_checks++; if (pix_count !== 32'd0) $display("FAIL reset_pix_count: got %0d want 0", pix_count); else n_pass++;
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_single_pixel();
        start_frame(32'h1000, 16'd640);
        m_ready = 1'b0;
        set_pix(16'd2, 16'd5, 24'h112233);
        step();
        pix_end = 1'b0;
        n_checks++; if (m_valid !== 1'b0) $display("FAIL single_valid_t1: got %b want 0", m_valid); else n_pass++;
        step();
        n_checks++; if (m_valid !== 1'b0) $display("FAIL single_valid_t2: got %b want 0", m_valid); else n_pass++;
        step();
        n_checks++; if (m_valid !== 1'b1) $display("FAIL single_valid_t3: got %b want 1", m_valid); else n_pass++;
        n_checks++; if (m_addr !== 32'h2414) $display("FAIL single_addr: got %h want 00002414", m_addr); else n_pass++;
        n_checks++; if (m_data !== 32'h00112233) $display("FAIL single_data: got %h want 00112233", m_data); else n_pass++;
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        n_checks++; if (m_valid !== 1'b0) $display("FAIL single_empty: got %b want 0", m_valid); else n_pass++;
        n_checks++; if (pix_count !== 32'd1) $display("FAIL single_count: got %0d want 1", pix_count); else n_pass++;
    endtask

    task automatic test_streaming();
        int pops = 0, first = -1, last = -1, addr_err = 0, rd_low = 0;
        start_frame(32'h0, 16'd640);
        m_ready = 1'b1;
        for (int c = 0; c < 110; c++) begin
            if (m_valid === 1'b1) begin
                if (m_addr !== 32'(pops * 4)) addr_err++;
                if (first < 0) first = c;
                last = c;
                pops++;
            end
            if (rd !== 1'b1) rd_low++;
            pix_end  = (c < 100);
            row_o    = 16'd0;
            column_o = 16'(c);
            step();
        end
        pix_end = 1'b0;
        n_checks++; if (pops !== 100) $display("FAIL stream_pops: got %0d want 100", pops); else n_pass++;
        n_checks++; if (last - first !== 99) $display("FAIL stream_span: got %0d want 99", last - first); else n_pass++;
        n_checks++; if (first !== 3) $display("FAIL stream_first: got %0d want 3", first); else n_pass++;
        n_checks++; if (addr_err !== 0) $display("FAIL stream_addr_order: got %0d bad want 0", addr_err); else n_pass++;
        n_checks++; if (rd_low !== 0) $display("FAIL stream_rd_low: got %0d cycles want 0", rd_low); else n_pass++;
        n_checks++; if (pix_count !== 32'd100) $display("FAIL stream_count: got %0d want 100", pix_count); else n_pass++;
        m_ready = 1'b0;
    endtask

    task automatic test_back_pressure();
        int n = 0;
        start_frame(32'h100, 16'd640);
        m_ready = 1'b0;
        while (rd === 1'b1 && n < 20) begin
            set_pix(16'd0, 16'(n), 24'h0);
            n++;
            step();
            pix_end = 1'b0;
        end
        n_checks++; if (n !== 6) $display("FAIL bp_strobes_before_rd_low: got %0d want 6", n); else n_pass++;
        // decoder lag: two further strobes after rd falls
        set_pix(16'd0, 16'd6, 24'h0); step();
        set_pix(16'd0, 16'd7, 24'h0); step();
        pix_end = 1'b0;
        step(); step(); step();
        n_checks++; if (rd !== 1'b0) $display("FAIL bp_rd_full: got %b want 0", rd); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL bp_overflow: got %b want 0", overflow); else n_pass++;
        n_checks++; if (m_addr !== 32'h100) $display("FAIL bp_head_hold: got %h want 00000100", m_addr); else n_pass++;
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (m_valid !== 1'b1 || m_addr !== 32'h100 + 32'(i * 4))
                $display("FAIL bp_drain_%0d: got v=%b addr=%h want v=1 addr=%h", i, m_valid, m_addr, 32'h100 + 32'(i * 4));
            else n_pass++;
            step();
        end
        n_checks++; if (m_valid !== 1'b0) $display("FAIL bp_drained: got %b want 0", m_valid); else n_pass++;
        n_checks++; if (pix_count !== 32'd8) $display("FAIL bp_count: got %0d want 8", pix_count); else n_pass++;
        m_ready = 1'b0;
    endtask

    task automatic test_overflow();
        int pops = 0;
        start_frame(32'h0, 16'd640);
        m_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            set_pix(16'd0, 16'(i), 24'h0);
            step();
        end
        pix_end = 1'b0;
        n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %b want 1", overflow); else n_pass++;
        step(); step(); step();
        n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else n_pass++;
        m_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (m_valid === 1'b1) begin
                n_checks++; if (m_addr !== 32'(pops * 4))
                    $display("FAIL ovf_drain_%0d: got %h want %h", pops, m_addr, 32'(pops * 4));
                else n_pass++;
                pops++;
            end
            step();
        end
        n_checks++; if (pops !== 8) $display("FAIL ovf_kept: got %0d want 8", pops); else n_pass++;
        start_frame(32'h0, 16'd640);
        n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow); else n_pass++;
        m_ready = 1'b0;
    endtask

    task automatic test_end_of_frame();
        int done_cnt = 0, done_cyc = -1;
        start_frame(32'h0, 16'd640);
        m_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            pix_end    = (c < 3);
            row_o      = 16'd0;
            column_o   = 16'(c);
            decode_end = (c >= 3);
            #1;
            if (frame_done === 1'b1) begin
                done_cnt++;
                done_cyc = c;
            end
            step();
        end
        n_checks++; if (done_cnt !== 1) $display("FAIL eof_pulses: got %0d want 1", done_cnt); else n_pass++;
        n_checks++; if (done_cyc !== 6) $display("FAIL eof_cycle: got %0d want 6", done_cyc); else n_pass++;
        decode_end = 1'b0;
        step(); step();
        decode_end = 1'b1;
        #1;
        n_checks++; if (frame_done !== 1'b0) $display("FAIL eof_empty_edge: got %b want 0", frame_done); else n_pass++;
        step();
        n_checks++; if (frame_done !== 1'b1) $display("FAIL eof_empty_plus1: got %b want 1", frame_done); else n_pass++;
        step();
        n_checks++; if (frame_done !== 1'b0) $display("FAIL eof_empty_single: got %b want 0", frame_done); else n_pass++;
        m_ready = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int done_cnt = 0;
        decode_end = 1'b0;
        start_frame(32'h0, 16'd640);
        m_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            set_pix(16'd0, 16'(i), 24'h0);
            step();
        end
        pix_end = 1'b0;
        step(); step(); step();
        m_ready = 1'b1; step(); m_ready = 1'b0; step();
        n_checks++; if (pix_count !== 32'd1 || rd !== 1'b0 || m_valid !== 1'b1)
            $display("FAIL rst_pre: got cnt=%0d rd=%b v=%b want 1 0 1", pix_count, rd, m_valid);
        else n_pass++;
        decode_end = 1'b1;
        step();
        reset_n    = 1'b0;
        decode_end = 1'b0;
        #1;
        n_checks++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid: got %b want 0", m_valid); else n_pass++;
        n_checks++; if (rd !== 1'b1) $display("FAIL rst_rd: got %b want 1", rd); else n_pass++;
        n_checks++; if (pix_count !== 32'd0) $display("FAIL rst_count: got %0d want 0", pix_count); else n_pass++;
        n_checks++; if (frame_done !== 1'b0) $display("FAIL rst_frame_done: got %b want 0", frame_done); else n_pass++;
        step();
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (frame_done === 1'b1) done_cnt++;
            step();
        end
        n_checks++; if (done_cnt !== 0) $display("FAIL rst_no_done: got %0d pulses want 0", done_cnt); else n_pass++;
        n_checks++; if (m_valid !== 1'b0) $display("FAIL rst_discard: got %b want 0", m_valid); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_streaming();
        test_back_pressure();
        test_overflow();
        test_end_of_frame();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
